// File: rtl/memtrace_sched_pkg.sv
// Purpose: shared types and constants for the memory-trace scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package memtrace_sched_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Header byte layout: [7] is_write, [6:5] size, [4:3] reserved, [2:0] lane.
    localparam int HDR_WRITE_BIT = 7;
    localparam int HDR_SIZE_MSB  = 6;
    localparam int HDR_SIZE_LSB  = 5;
    localparam int HDR_LANE_MSB  = 2;
    localparam int HDR_LANE_LSB  = 0;

    localparam logic [7:0] END_MARKER = 8'hFF;

    // States in which the block accepts trace bytes.
    function automatic logic is_parse_state(input state_t s);
        return (s == ST_HDR) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/memtrace_credit.sv
// Purpose: outstanding-request credit counter for one request lane.
// Latency: count updates on the clock edge after inc/dec; full is a decode of the count.
// Backpressure: full blocks further issues until a dec frees a credit.
// Ports: clock, reset (sync, active-high), inc (request handshaken),
//        dec (completion returned), full (count at limit).
module memtrace_credit #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] count;

    // Simultaneous inc and dec cancel. A dec at zero is a stray completion and is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CW'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign full = (count >= CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/memtrace_sched.sv
// Purpose: parse byte-serial trace records and dispatch them as requests to credit-throttled lanes.
// Latency: request valid the cycle after the last record byte; next header accepted the cycle after handshake.
// Backpressure: trace_ready drops while a request waits in ISSUE; req_valid is held low while the lane's credit is full.
// Ports: clock, reset (sync, active-high); trace_valid/trace_ready/trace_bits byte stream in;
//        req_valid (one-hot per lane)/req_ready with shared req_is_write, req_size, req_addr, req_data;
//        resp_valid per-lane credit return; done/err sticky status.
// Option: MEMTRACE_SCHED_STATS_EN adds stat_issued and stat_stall counters.
module memtrace_sched
    import memtrace_sched_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trace_valid,
    output logic                 trace_ready,
    input  logic [7:0]           trace_bits,
    output logic [NUM_LANES-1:0] req_valid,
    input  logic [NUM_LANES-1:0] req_ready,
    output logic                 req_is_write,
    output logic [1:0]           req_size,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [DATA_W-1:0]    req_data,
    input  logic [NUM_LANES-1:0] resp_valid,
    output logic                 done,
    output logic                 err
`ifdef MEMTRACE_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           lane;
    logic                 take, hs;
    logic                 addr_last, data_last;
    logic                 hdr_end, hdr_bad;
    logic [NUM_LANES-1:0] full;
    logic [ADDR_W+7:0]    addr_shift;
    logic [DATA_W+7:0]    data_shift;

    assign take      = trace_valid && trace_ready;
    assign hs        = |(req_valid & req_ready);
    assign addr_last = (cnt == CNT_W'(ADDR_BYTES - 1));
    assign data_last = (cnt == CNT_W'(DATA_BYTES - 1));
    assign hdr_end   = (trace_bits == END_MARKER);
    assign hdr_bad   = (int'(trace_bits[HDR_LANE_MSB:HDR_LANE_LSB]) >= NUM_LANES);

    // Little-endian assembly: each new byte enters at the top and earlier bytes
    // shift down, so the first byte ends up in the least significant position.
    assign addr_shift = {trace_bits, req_addr};
    assign data_shift = {trace_bits, req_data};

    always_comb begin
        state_n = state;
        unique case (state)
            ST_HDR: begin
                if (take) begin
                    if (hdr_end)      state_n = ST_DONE;
                    else if (hdr_bad) state_n = ST_ERR;
                    else              state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (take && addr_last) state_n = req_is_write ? ST_DATA : ST_ISSUE;
            end
            ST_DATA: begin
                if (take && data_last) state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hs) state_n = ST_HDR;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_HDR;
            trace_ready  <= 1'b0;
            cnt          <= '0;
            lane         <= '0;
            req_is_write <= 1'b0;
            req_size     <= '0;
            req_addr     <= '0;
            req_data     <= '0;
        end else begin
            state       <= state_n;
            // Registered so the ready seen by the source is a clean flop output.
            trace_ready <= is_parse_state(state_n);
            if (take) begin
                unique case (state)
                    ST_HDR: begin
                        if (!hdr_end && !hdr_bad) begin
                            cnt          <= '0;
                            req_is_write <= trace_bits[HDR_WRITE_BIT];
                            req_size     <= trace_bits[HDR_SIZE_MSB:HDR_SIZE_LSB];
                            lane         <= trace_bits[HDR_LANE_MSB:HDR_LANE_LSB];
                            // Reads carry no data bytes; clear any previous write data.
                            req_data     <= '0;
                        end
                    end
                    ST_ADDR: begin
                        req_addr <= addr_shift[ADDR_W+7:8];
                        cnt      <= addr_last ? '0 : cnt + CNT_W'(1);
                    end
                    ST_DATA: begin
                        req_data <= data_shift[DATA_W+7:8];
                        cnt      <= data_last ? '0 : cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign req_valid[i] = (state == ST_ISSUE) && (int'(lane) == i) && !full[i];

        memtrace_credit #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_credit (
            .clock (clock),
            .reset (reset),
            .inc   (req_valid[i] && req_ready[i]),
            .dec   (resp_valid[i]),
            .full  (full[i])
        );
    end

    // DONE is only reachable from HDR, so every issued request has already handshaken.
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

`ifdef MEMTRACE_SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (hs) stat_issued <= stat_issued + 32'd1;
            if ((state == ST_ISSUE) && !hs) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memtrace_sched.sv
module tb_memtrace_sched;

    localparam int NL = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          trace_valid = 1'b0;
    logic          trace_ready;
    logic [7:0]    trace_bits = 8'h00;
    logic [NL-1:0] req_valid;
    logic [NL-1:0] req_ready = '0;
    logic          req_is_write;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [NL-1:0] resp_valid = '0;
    logic          done;
    logic          err;
`ifdef MEMTRACE_SCHED_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memtrace_sched #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_bits   (trace_bits),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_write (req_is_write),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .done         (done),
        .err          (err)
`ifdef MEMTRACE_SCHED_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_stall   (stat_stall)
`endif
    );

    typedef struct {
        logic [7:0]    hdr;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [NL-1:0] exp_vld;
        logic          exp_wr;
        logic [1:0]    exp_size;
        logic [31:0]   exp_addr;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        trace_valid = 1'b1;
        trace_bits  = b;
        @(negedge clock);
        while (!trace_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!trace_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: got trace_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        trace_valid = 1'b0;
    endtask

    task automatic send_record(input logic [7:0] hdr, input logic [31:0] addr, input logic [31:0] data);
        send_byte(hdr);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        if (hdr[7]) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    endtask

    // Checks the request presented in the cycle right after the last byte, then steps one edge.
    task automatic check_req(input string name, input logic [NL-1:0] vld, input logic wr,
                             input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        check({name, "_valid"}, 64'(req_valid), 64'(vld));
        check({name, "_write"}, 64'(req_is_write), 64'(wr));
        check({name, "_size"},  64'(req_size), 64'(size));
        check({name, "_addr"},  64'(req_addr), 64'(addr));
        check({name, "_data"},  64'(req_data), 64'(data));
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        resp_valid = '1;
        cycles(MO + 1);
        resp_valid = '0;
    endtask

    task automatic check_reset_values(input string name);
        @(negedge clock);
        check({name, "_trace_ready"}, 64'(trace_ready), 64'(0));
        check({name, "_req_valid"},   64'(req_valid), 64'(0));
        check({name, "_is_write"},    64'(req_is_write), 64'(0));
        check({name, "_size"},        64'(req_size), 64'(0));
        check({name, "_addr"},        64'(req_addr), 64'(0));
        check({name, "_data"},        64'(req_data), 64'(0));
        check({name, "_done"},        64'(done), 64'(0));
        check({name, "_err"},         64'(err), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h02, 32'h80000010, 32'h00000000, 4'b0100, 1'b0, 2'd0, 32'h80000010, 32'h00000000};
        vecs[1] = '{8'hC1, 32'h00001000, 32'hDEADBEEF, 4'b0010, 1'b1, 2'd2, 32'h00001000, 32'hDEADBEEF};
        vecs[2] = '{8'h3B, 32'h12345678, 32'hFFFFFFFF, 4'b1000, 1'b0, 2'd1, 32'h12345678, 32'h00000000};
        vecs[3] = '{8'hE0, 32'hFFFFFFFF, 32'h01234567, 4'b0001, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h01234567};
        vecs[4] = '{8'h41, 32'hA5A55A5A, 32'h00000000, 4'b0010, 1'b0, 2'd2, 32'hA5A55A5A, 32'h00000000};

        // Reset state.
        cycles(2);
        check_reset_values("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven records with the lanes always ready.
        req_ready = '1;
        for (int v = 0; v < 5; v++) begin
            send_record(vecs[v].hdr, vecs[v].addr, vecs[v].data);
            check_req($sformatf("vec%0d", v), vecs[v].exp_vld, vecs[v].exp_wr,
                      vecs[v].exp_size, vecs[v].exp_addr, vecs[v].exp_data);
            @(negedge clock);
            check($sformatf("vec%0d_post_hs_valid", v), 64'(req_valid), 64'(0));
            check($sformatf("vec%0d_post_hs_ready", v), 64'(trace_ready), 64'(1));
            @(posedge clock);
            #1;
        end
        drain();

        // Lane 0 credit limit: four issue, the fifth waits for a returned credit.
        for (int k = 0; k < 4; k++) begin
            send_record(8'h00, 32'h100 + k, 32'h0);
            check_req($sformatf("lane0_r%0d", k), 4'b0001, 1'b0, 2'd0, 32'h100 + k, 32'h0);
        end
        send_record(8'h00, 32'h200, 32'h0);
        @(negedge clock);
        check("lane0_full_hold0", 64'(req_valid), 64'(0));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("lane0_full_hold1", 64'(req_valid), 64'(0));
        @(posedge clock);
        #1;
        resp_valid = 4'b0001;
        @(negedge clock);
        check("lane0_full_resp_cycle", 64'(req_valid), 64'(0));
        @(posedge clock);
        #1;
        resp_valid = '0;
        @(negedge clock);
        check("lane0_freed_valid", 64'(req_valid), 64'(4'b0001));
        check("lane0_freed_addr", 64'(req_addr), 64'(32'h200));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("lane0_freed_hs", 64'(req_valid), 64'(0));
        @(posedge clock);
        #1;
        drain();

        // Lane 3: issue and completion in the same cycle at credit 2 leaves it at 2.
        send_record(8'h03, 32'h311, 32'h0);
        check_req("lane3_a", 4'b1000, 1'b0, 2'd0, 32'h311, 32'h0);
        send_record(8'h03, 32'h322, 32'h0);
        check_req("lane3_b", 4'b1000, 1'b0, 2'd0, 32'h322, 32'h0);
        req_ready = '0;
        send_record(8'h03, 32'h333, 32'h0);
        @(negedge clock);
        check("lane3_bp_valid0", 64'(req_valid), 64'(4'b1000));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("lane3_bp_valid1", 64'(req_valid), 64'(4'b1000));
        check("lane3_bp_addr", 64'(req_addr), 64'(32'h333));
        check("lane3_bp_trace_ready", 64'(trace_ready), 64'(0));
        @(posedge clock);
        #1;
        req_ready  = 4'b1000;
        resp_valid = 4'b1000;
        @(negedge clock);
        check("lane3_same_cycle_valid", 64'(req_valid), 64'(4'b1000));
        @(posedge clock);
        #1;
        resp_valid = '0;
        send_record(8'h03, 32'h344, 32'h0);
        check_req("lane3_c", 4'b1000, 1'b0, 2'd0, 32'h344, 32'h0);
        send_record(8'h03, 32'h355, 32'h0);
        check_req("lane3_d", 4'b1000, 1'b0, 2'd0, 32'h355, 32'h0);
        send_record(8'h03, 32'h366, 32'h0);
        @(negedge clock);
        check("lane3_full", 64'(req_valid), 64'(0));
        @(posedge clock);
        #1;
        resp_valid = 4'b1000;
        cycles(1);
        resp_valid = '0;
        @(negedge clock);
        check("lane3_freed_valid", 64'(req_valid), 64'(4'b1000));
        @(posedge clock);
        #1;
        req_ready = '1;
        drain();

        // Reset mid-record with lane 2 credits full: fields and credits are discarded.
        for (int k = 0; k < 4; k++) begin
            send_record(8'h02, 32'h400 + k, 32'h0);
            check_req($sformatf("lane2_fill%0d", k), 4'b0100, 1'b0, 2'd0, 32'h400 + k, 32'h0);
        end
        send_byte(8'h82);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        cycles(1);
        check_reset_values("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_record(8'h02, 32'hCAFEF00D, 32'h0);
        check_req("post_reset", 4'b0100, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0);

        // Bad lane id: terminal error, bytes refused.
        send_byte(8'h07);
        @(negedge clock);
        check("err_set", 64'(err), 64'(1));
        check("err_trace_ready", 64'(trace_ready), 64'(0));
        check("err_req_valid", 64'(req_valid), 64'(0));
        trace_valid = 1'b1;
        trace_bits  = 8'hFF;
        cycles(4);
        @(negedge clock);
        check("err_sticky", 64'(err), 64'(1));
        check("err_no_done", 64'(done), 64'(0));
        check("err_ready_low", 64'(trace_ready), 64'(0));
        @(posedge clock);
        #1;
        trace_valid = 1'b0;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clock);
        check("err_cleared", 64'(err), 64'(0));
        @(posedge clock);
        #1;

        // End-of-trace marker.
        send_byte(8'hFF);
        @(negedge clock);
        check("done_set", 64'(done), 64'(1));
        check("done_req_valid", 64'(req_valid), 64'(0));
        check("done_trace_ready", 64'(trace_ready), 64'(0));
        resp_valid = '1;
        cycles(3);
        resp_valid = '0;
        @(negedge clock);
        check("done_sticky", 64'(done), 64'(1));
        check("done_no_err", 64'(err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memtrace_sched.md
# memtrace_sched

Consumes the byte-serial memory-trace stream produced by the simulation trace source and assembles complete trace records. Dispatches each record as a request to one of NUM_LANES requester lanes, throttled by per-lane outstanding-request credits. Sits between the trace source and the per-lane memory request generators in the simulation harness, and sequences trace playback.

## Interface
- NUM_LANES, 4: number of request lanes, 1..8
- ADDR_W, 32: request address width, multiple of 8
- DATA_W, 32: request write-data width, multiple of 8
- MAX_OUTSTANDING, 4: per-lane credit limit, ≥1

Ports (reset: reset, synchronous, active-high; clock: clock):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- trace_valid  in  1  trace byte available
- trace_ready  out  1  block accepts trace byte
- trace_bits  in  8  trace byte
- req_valid  out  NUM_LANES  one-hot request valid per lane
- req_ready  in  NUM_LANES  lane accepts request
- req_is_write  out  1  shared: 1 = write
- req_size  out  2  shared: log2 bytes
- req_addr  out  ADDR_W  shared address
- req_data  out  DATA_W  shared write data; 0 for reads
- resp_valid  in  NUM_LANES  per-lane completion pulse, returns one credit
- done  out  1  end-of-trace marker consumed, sticky
- err  out  1  bad lane id seen, sticky

## Operation
- Record format: header byte, then ADDR_W/8 address bytes, then DATA_W/8 data bytes for writes only; multi-byte fields little-endian.
- Header bits: [7] is_write, [6:5] size, [4:3] reserved (ignored), [2:0] lane. Header 0xFF is the end-of-trace marker.
- FSM states: HDR, ADDR, DATA, ISSUE, DONE, ERR.
  - HDR: on handshake, 0xFF → DONE; lane ≥ NUM_LANES → ERR; otherwise latch fields → ADDR.
  - ADDR: byte counter 0..ADDR_W/8-1. Last byte → DATA if write, else ISSUE.
  - DATA: byte counter 0..DATA_W/8-1. Last byte → ISSUE.
  - ISSUE: req_valid[lane]=1 while credit[lane] < MAX_OUTSTANDING. On req_valid & req_ready → HDR, credit[lane]+1.
  - DONE, ERR: terminal; trace_ready=0, req_valid=0. Left only by reset.
- Credits: one counter per lane, width clog2(MAX_OUTSTANDING+1).
  - Issue and resp_valid on the same lane in the same cycle: counter unchanged.
  - resp_valid on a lane at count 0: ignored, saturate at 0.
  - resp_valid is honoured in every state, including DONE and ERR.
- done asserts only after the last issued request has handshaken. Outstanding credits do not delay done.
- Shared req_* buses hold stable from ISSUE entry until handshake.

## Timing
- Reset values: trace_ready=0, req_valid=0, req_is_write=0, req_size=0, req_addr=0, req_data=0, done=0, err=0, all credits 0, state HDR.
- trace_ready is a registered state decode: 1 in HDR/ADDR/DATA, 0 otherwise. At most one byte accepted per cycle; idle trace_valid cycles stall the counters.
- Read record: header plus 4 addr bytes over ≥5 cycles; req_valid rises the cycle after the last byte is accepted.
- Write record (32/32): ≥9 byte cycles, then req_valid next cycle.
- Handshake occurs in cycle T; the next header byte can be accepted in T+1.
- req_valid may drop only on handshake. It never rises while the credit is full and rises the cycle after a freeing resp_valid.
- Reset mid-record discards partial fields and credits.

## Configuration
- MEMTRACE_SCHED_STATS_EN
  - Defined: adds outputs stat_issued (32, total handshaken requests) and stat_stall (32, cycles in ISSUE with req_valid=0 or req_ready=0). Both reset to 0 and wrap on overflow.
  - Undefined: these ports and their counters are absent; behaviour is otherwise identical.

## Structure
- Package memtrace_sched_pkg holds: state enum, header bit-position constants, end-marker constant 8'hFF.
- One sub-module, memtrace_credit: a single-lane credit counter instantiated NUM_LANES times. Inputs inc and dec; outputs full.

## Test plan
- Read record bytes 0x02,0x10,0x00,0x00,0x80 with req_ready=1 → req_valid=4'b0100, addr=0x80000010, is_write=0, size=0, data=0; credit[2]=1.
- Write 0xC1, addr 0x1000, data 0xDEADBEEF → lane 1 request, size=2, data=0xDEADBEEF, issued 1 cycle after the 9th byte.
- Five reads to lane 0, no resp_valid → 4 issued, 5th held with req_valid=0. Pulse resp_valid[0] → 5th issues the next cycle.
- Issue and resp_valid on lane 3 in the same cycle at credit 2 → credit stays 2.
- Header 0x07 with NUM_LANES=4 → err=1, trace_ready=0 permanently. Header 0xFF → done=1, no req_valid.
- Reset asserted after 2 of 4 address bytes → outputs at reset values; the next record parses cleanly from a fresh header.
